// File: rtl/list_range_source.sv
// rtl/list_range_source.sv - list-stream responder producing an arithmetic sequence
module list_range_source #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             ready,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] count,
  output logic             done,
  input  logic             req,
  output logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             value_valid
);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, DELAY, ACK, WAIT_DROP, END_LIST
  } state_t;

  // Delay counter is preloaded with LATENCY-1; DELAY hands over to ACK when it reaches 1,
  // so the ack register is set on the edge where the count would become 0.
  localparam logic [3:0] DLY_LOAD = 4'(LATENCY - 1);

  state_t           state, next_state;
  logic             ready_q;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] stp;
  logic [WIDTH-1:0] remaining;
  logic [3:0]       dly;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a low ready pulls every active state back to IDLE and beats a pending ack
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (ready && !ready_q) next_state = WAIT_REQ;
      WAIT_REQ:  if (req) next_state = (LATENCY == 1) ? ACK : DELAY;
      DELAY:     if (dly <= 4'd1) next_state = ACK;
      ACK:       next_state = value_valid ? WAIT_DROP : END_LIST;
      WAIT_DROP: if (!req) next_state = WAIT_REQ;
      END_LIST:  next_state = END_LIST;
      default:   next_state = IDLE;
    endcase
    if (state != IDLE && !ready) next_state = IDLE;
  end

  // Datapath and registered outputs, all computed from the upcoming state.
  // ready_q resets high so a ready level held through reset is not taken as a fresh start.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      ready_q     <= 1'b1;
      cur         <= '0;
      stp         <= '0;
      remaining   <= '0;
      dly         <= '0;
      ack         <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      ready_q     <= ready;
      ack         <= 1'b0;
      value_valid <= 1'b0;
      done        <= (next_state == END_LIST) && (done || (state == END_LIST && !req));
      if (state == IDLE && next_state == WAIT_REQ) begin
        cur       <= first;
        stp       <= step;
        remaining <= count;
      end
      if (next_state == DELAY) begin
        dly <= (state == DELAY) ? dly - 4'd1 : DLY_LOAD;
      end
      if (next_state == ACK) begin
        ack <= 1'b1;
        if (remaining != '0) begin
          value       <= cur;
          value_valid <= 1'b1;
          cur         <= cur + stp;
          remaining   <= remaining - 1'b1;
        end else begin
          value <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_list_range_source.sv
// tb/tb_list_range_source.sv - self-checking bench for list_range_source
module tb_list_range_source;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ready;
  logic [7:0] first, step, count;
  logic       req1, req4;
  logic       done1, ack1, valid1;
  logic       done4, ack4, valid4;
  logic [7:0] value1, value4;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  list_range_source #(.WIDTH(8), .LATENCY(1)) dut1 (
    .CLOCK_50(clk), .reset_n(reset_n), .ready(ready), .first(first), .step(step),
    .count(count), .done(done1), .req(req1), .ack(ack1), .value(value1), .value_valid(valid1)
  );

  list_range_source #(.WIDTH(8), .LATENCY(4)) dut4 (
    .CLOCK_50(clk), .reset_n(reset_n), .ready(ready), .first(first), .step(step),
    .count(count), .done(done4), .req(req4), .ack(ack4), .value(value4), .value_valid(valid4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v);
    if (sel == 1) req4 = v;
    else          req1 = v;
  endtask

  // Called at a negedge; returns at a negedge with the block waiting for a request
  task automatic start_list(input logic [7:0] f, input logic [7:0] s, input logic [7:0] c);
    ready = 1'b0;
    first = f;
    step  = s;
    count = c;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
  endtask

  // One 4-phase handshake: raise req, expect an ack exactly lat cycles later,
  // optionally keep req high for hold more cycles, then drop and idle one cycle
  task automatic do_req(input int sel, input int lat, input logic [7:0] ev, input logic evalid,
                        input int hold, input string tag);
    int   cyc = 0;
    int   extra = 0;
    logic got = 1'b0;
    set_req(sel, 1'b1);
    while (!got && cyc < lat + 4) begin
      @(negedge clk);
      cyc++;
      got = (sel == 1) ? ack4 : ack1;
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_value"}, (sel == 1) ? value4 : value1, ev);
    chk({tag, "_valid"}, (sel == 1) ? valid4 : valid1, evalid);
    repeat (hold) begin
      @(negedge clk);
      if ((sel == 1) ? ack4 : ack1) extra++;
    end
    chk({tag, "_held_req_acks"}, extra, 0);
    set_req(sel, 1'b0);
    @(negedge clk);
    chk({tag, "_ack_one_cycle"}, (sel == 1) ? ack4 : ack1, 1'b0);
    @(negedge clk);
  endtask

  // Reference: element i is (f + i*s) mod 256, followed by one end-of-list response
  task automatic run_list(input int sel, input int lat, input logic [7:0] f, input logic [7:0] s,
                          input logic [7:0] c, input string tag);
    int extra = 0;
    start_list(f, s, c);
    for (int i = 0; i < int'(c); i++) begin
      logic [7:0] e;
      e = 8'(int'(f) + i * int'(s));
      do_req(sel, lat, e, 1'b1, 0, $sformatf("%s_el%0d", tag, i));
    end
    do_req(sel, lat, 8'd0, 1'b0, 0, {tag, "_eol"});
    chk({tag, "_done"}, (sel == 1) ? done4 : done1, 1'b1);
    set_req(sel, 1'b1);
    repeat (lat + 3) begin
      @(negedge clk);
      if ((sel == 1) ? ack4 : ack1) extra++;
    end
    chk({tag, "_no_ack_after_end"}, extra, 0);
    chk({tag, "_done_held"}, (sel == 1) ? done4 : done1, 1'b1);
    set_req(sel, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int extra;
    reset_n = 1'b0;
    ready   = 1'b0;
    first   = '0;
    step    = '0;
    count   = '0;
    req1    = 1'b0;
    req4    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", {ack4, ack1}, 2'b00);
    chk("reset_done", {done4, done1}, 2'b00);
    chk("reset_valid", {valid4, valid1}, 2'b00);
    chk("reset_value", {value4, value1}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_list(0, 1, 8'd3, 8'd2, 8'd4, "basic");
    run_list(0, 1, 8'd77, 8'd9, 8'd0, "empty");
    run_list(0, 1, 8'd250, 8'd3, 8'd3, "wrap");
    run_list(1, 4, 8'd20, 8'd5, 8'd2, "lat4_list");

    // Held request on the LATENCY=4 block: one ack only, next needs a fresh rise
    start_list(8'd5, 8'd1, 8'd3);
    do_req(1, 4, 8'd5, 1'b1, 16, "lat4_held");
    do_req(1, 4, 8'd6, 1'b1, 0, "lat4_second");

    // Abort coinciding with the second ack
    start_list(8'd40, 8'd1, 8'd5);
    do_req(0, 1, 8'd40, 1'b1, 0, "abort_first");
    req1  = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    chk("abort_ack", ack1, 1'b0);
    chk("abort_done", done1, 1'b0);
    chk("abort_valid", valid1, 1'b0);
    req1 = 1'b0;
    @(negedge clk);
    start_list(8'd10, 8'd4, 8'd2);
    do_req(0, 1, 8'd10, 1'b1, 0, "abort_restart");

    // Reset mid-stream with a request pending
    start_list(8'd100, 8'd7, 8'd4);
    do_req(0, 1, 8'd100, 1'b1, 0, "rst_first");
    req1    = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {ack1, done1, valid1, value1}, 11'd0);
    reset_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack1) extra++;
    end
    chk("rst_no_ack", extra, 0);
    req1 = 1'b0;
    @(negedge clk);
    run_list(0, 1, 8'd100, 8'd7, 8'd2, "rst_restart");

    // Randomized lists on both latencies
    for (int n = 0; n < 8; n++) begin
      logic [7:0] f, s, c;
      f = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 5));
      run_list(n % 2, (n % 2 == 1) ? 4 : 1, f, s, c, $sformatf("rand%0d", n));
    end

    run_list(0, 1, 8'd1, 8'd1, 8'd255, "full255");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
